// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S slave receiver.
package i2s_pkg;

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } state_e;

    localparam int   DATA_WIDTH_DEFAULT = 16;
    localparam logic LEFT_CH            = 1'b0;
    localparam logic RIGHT_CH           = 1'b1;

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchronizer for one asynchronous bus line; clears to 0 on reset.
module i2s_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: captures MSB-aligned left/right words into a valid/ready frame output.
// Optional saturating overrun counter on port ovr_count when I2S_RX_OVERRUN_CNT_EN is defined.
module i2s_slave_rx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SCK,
    input  logic                  WS,
    input  logic                  sd_out,
    input  logic                  en,
    output logic [DATA_WIDTH-1:0] rx_left,
    output logic [DATA_WIDTH-1:0] rx_right,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overrun,
`ifdef I2S_RX_OVERRUN_CNT_EN
    output logic [7:0]            ovr_count,
`endif
    output logic [1:0]            dbg_state
);

    localparam int                    CNT_W   = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic sck_s, ws_s, sd_s;

    i2s_sync u_sync_sck (.clk(clk), .reset(reset), .d(SCK),    .q(sck_s));
    i2s_sync u_sync_ws  (.clk(clk), .reset(reset), .d(WS),     .q(ws_s));
    i2s_sync u_sync_sd  (.clk(clk), .reset(reset), .d(sd_out), .q(sd_s));

    state_e                state_q, state_d;
    logic                  sck_prev_q, sck_prev_d;
    logic                  ws_prev_q, ws_prev_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] held_q, held_d;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic [DATA_WIDTH-1:0] right_q, right_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;

    logic                  bit_evt, ws_rise, ws_fall, frame_evt;
    logic [DATA_WIDTH-1:0] word;

    // ws_prev_q holds WS as seen at the previous bit event, so a change is judged per bit.
    assign bit_evt = sck_s & ~sck_prev_q;
    assign ws_rise = bit_evt && (ws_prev_q == LEFT_CH)  && (ws_s == RIGHT_CH);
    assign ws_fall = bit_evt && (ws_prev_q == RIGHT_CH) && (ws_s == LEFT_CH);
    // Current word with this bit placed at its MSB-aligned slot; the mask is zero once saturated.
    assign word    = shift_q | (sd_s ? (MSB_ONE >> cnt_q) : '0);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        held_d     = held_q;
        frame_evt  = 1'b0;
        sck_prev_d = sck_s;
        ws_prev_d  = bit_evt ? ws_s : ws_prev_q;

        if (!en) begin
            state_d = SYNC_WAIT;
            shift_d = '0;
            cnt_d   = '0;
            held_d  = '0;
        end else if (bit_evt) begin
            if (ws_rise || ws_fall) begin
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d = word;
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end
            case (state_q)
                SYNC_WAIT: if (ws_fall) state_d = LEFT;
                LEFT: if (ws_rise) begin
                    held_d  = word;
                    state_d = RIGHT;
                end
                RIGHT: if (ws_fall) begin
                    frame_evt = 1'b1;
                    state_d   = LEFT;
                end
                default: state_d = SYNC_WAIT;
            endcase
        end
    end

    always_comb begin
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (frame_evt) begin
            if (!valid_q || rx_ready) begin
                left_d  = held_q;
                right_d = word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= SYNC_WAIT;
            sck_prev_q <= 1'b0;
            ws_prev_q  <= 1'b0;
            shift_q    <= '0;
            cnt_q      <= '0;
            held_q     <= '0;
            left_q     <= '0;
            right_q    <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sck_prev_q <= sck_prev_d;
            ws_prev_q  <= ws_prev_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            held_q     <= held_d;
            left_q     <= left_d;
            right_q    <= right_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef I2S_RX_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (overrun_d && (ovr_cnt_q != 8'hFF)) ovr_cnt_d = ovr_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovr_cnt_q <= 8'd0;
        else        ovr_cnt_q <= ovr_cnt_d;
    end

    assign ovr_count = ovr_cnt_q;
`endif

    assign rx_left   = left_q;
    assign rx_right  = right_q;
    assign rx_valid  = valid_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Bench for i2s_slave_rx: I2S stream driver, stream-level frame model and a handshake scoreboard.
`timescale 1ns/1ps
module tb_i2s_slave_rx;
    import i2s_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, SCK, WS, sd_out, en, rx_ready;
    logic [W-1:0] rx_left, rx_right;
    logic         rx_valid, overrun;
    logic [1:0]   dbg_state;
`ifdef I2S_RX_OVERRUN_CNT_EN
    logic [7:0]   ovr_count;
`endif

    always #5 clk = ~clk;

    i2s_slave_rx #(.DATA_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .SCK(SCK), .WS(WS), .sd_out(sd_out), .en(en),
        .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .overrun(overrun),
`ifdef I2S_RX_OVERRUN_CNT_EN
        .ovr_count(ovr_count),
`endif
        .dbg_state(dbg_state)
    );

    int             n_tests = 0;
    int             n_fail  = 0;
    int             ovr_seen = 0;
    int             ovr_exp  = 0;
    logic [2*W-1:0] exp_q[$];

    // Stream-level model: a frame is an aligned left word plus right word, closed by the next WS fall.
    logic           last_ws   = 1'b0;
    logic           pend      = 1'b0;
    bit             m_synced  = 1'b0;
    bit             m_left_ok = 1'b0;
    bit             m_busy    = 1'b0;
    logic [W-1:0]   m_left;
    logic [31:0]    prev_word = '0;
    int             prev_n    = 16;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] align(input logic [31:0] w, input int n);
        logic [63:0] t;
        t = {32'b0, w} << (64 - n);
        return t[63:64-W];
    endfunction

    function automatic logic [31:0] rand_word(input int n);
        logic [31:0] w;
        w = $urandom;
        if (n < 32) w = w & ((32'h1 << n) - 32'h1);
        return w;
    endfunction

    task automatic push_frame(input logic [W-1:0] l, input logic [W-1:0] r);
        if (m_busy) ovr_exp++;
        else begin
            exp_q.push_back({l, r});
            if (!rx_ready) m_busy = 1'b1;
        end
    endtask

    task automatic send_bit(input logic ws, input logic sd);
        SCK = 1'b0; WS = ws; sd_out = sd;
        repeat (4) @(posedge clk);
        #1 SCK = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic disturb(input int kind);
        m_synced  = 1'b0;
        m_left_ok = 1'b0;
        if (kind == 1) begin
            en = 1'b0;
            repeat (6) @(posedge clk);
            #1 en = 1'b1;
        end else begin
            reset = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check("midreset_left", rx_left, 0);
            check("midreset_right", rx_right, 0);
            check("midreset_valid", rx_valid, 0);
            check("midreset_overrun", overrun, 0);
            check("midreset_state", dbg_state, SYNC_WAIT);
            reset = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    // The first bit of a channel is the previous channel's LSB (one-bit delay).
    task automatic send_channel(input logic ws, input logic [31:0] word, input int n,
                                input int disturb_at = -1, input int kind = 0);
        if (ws != last_ws) begin
            if (ws) begin
                if (m_synced) begin
                    m_left    = align(prev_word, prev_n);
                    m_left_ok = 1'b1;
                end
            end else begin
                if (m_synced && m_left_ok) push_frame(m_left, align(prev_word, prev_n));
                m_synced  = 1'b1;
                m_left_ok = 1'b0;
            end
        end
        last_ws   = ws;
        prev_word = word;
        prev_n    = n;
        send_bit(ws, pend);
        for (int i = n - 1; i >= 1; i--) begin
            if (i == disturb_at) disturb(kind);
            send_bit(ws, word[i]);
        end
        pend = word[0];
    endtask

    task automatic send_frame(input logic [31:0] l, input int nl, input logic [31:0] r, input int nr);
        send_channel(1'b0, l, nl);
        send_channel(1'b1, r, nr);
    endtask

    always @(negedge clk) begin
        logic [2*W-1:0] e;
        if (reset && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame: got %h/%h expected none", rx_left, rx_right);
            end else begin
                e = exp_q.pop_front();
                check("frame", {rx_left, rx_right}, e);
            end
        end
        if (reset && overrun) ovr_seen++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; SCK = 1'b0; WS = 1'b0; sd_out = 1'b0; en = 1'b1; rx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_left", rx_left, 0);
        check("reset_right", rx_right, 0);
        check("reset_valid", rx_valid, 0);
        check("reset_overrun", overrun, 0);
        check("reset_state", dbg_state, SYNC_WAIT);
`ifdef I2S_RX_OVERRUN_CNT_EN
        check("reset_ovr_count", ovr_count, 0);
`endif
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Bus starts mid-right-word: nothing until a full aligned pair.
        send_channel(1'b1, 32'h15, 5);
        send_frame(32'hA5C3, 16, 32'h5A3C, 16);
        send_frame(32'h123456, 24, 32'h89ABCD, 24);
        send_frame(32'hF0, 8, 32'h0F, 8);

        // Enable dropped mid-left-word: that frame is lost, the next one realigns.
        send_channel(1'b0, 32'hBEEF, 16, 9, 1);
        send_channel(1'b1, 32'hCAFE, 16);
        send_frame(32'h1357, 16, 32'h2468, 16);

        // Reset mid-left-word, then an aligned frame must be captured again.
        send_channel(1'b0, 32'h7777, 16, 7, 2);
        send_channel(1'b1, 32'h8888, 16);
        send_frame(32'h0F0F, 16, 32'hF0F0, 16);

        for (int k = 0; k < 12; k++) begin
            int nl, nr;
            nl = $urandom_range(8, 32);
            nr = $urandom_range(8, 32);
            send_frame(rand_word(nl), nl, rand_word(nr), nr);
        end

        // Consumer stalls across two frames: first is held, second dropped.
        send_channel(1'b0, rand_word(16), 16);
        rx_ready = 1'b0;
        send_channel(1'b1, rand_word(16), 16);
        send_frame(rand_word(16), 16, rand_word(16), 16);
        send_channel(1'b0, 32'h4242, 16);
        repeat (4) @(posedge clk);
        #1;
        check("hold_valid", rx_valid, 1);
        check("hold_frame", {rx_left, rx_right}, exp_q.size() > 0 ? exp_q[0] : '1);
        check("overrun_pulses", ovr_seen, ovr_exp);
        check("state_left", dbg_state, LEFT);
`ifdef I2S_RX_OVERRUN_CNT_EN
        check("ovr_count_one", ovr_count, 1);
`endif
        rx_ready = 1'b1;
        m_busy   = 1'b0;
        send_channel(1'b1, 32'h9999, 16);
        send_channel(1'b0, rand_word(16), 16);
        repeat (20) @(posedge clk);
        #1;

        check("queue_drained", exp_q.size(), 0);
        check("overrun_total", ovr_seen, ovr_exp);
`ifdef I2S_RX_OVERRUN_CNT_EN
        check("ovr_count_final", ovr_count, ovr_exp);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
